// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage load/store engine with req/ack bus, load extension, stall and fault reporting
module memory_access_unit #(
  parameter int BIT_COUNT      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MemValid,
  input  logic                 MemWrite,
  input  logic [2:0]           MemFunct3,
  input  logic [BIT_COUNT-1:0] ALUResult,
  input  logic [BIT_COUNT-1:0] StoreData,
  output logic                 DMemReq,
  output logic                 DMemWe,
  output logic [BIT_COUNT-1:0] DMemAddr,
  output logic [BIT_COUNT-1:0] DMemWData,
  output logic [3:0]           DMemByteEn,
  input  logic                 DMemAck,
  input  logic [BIT_COUNT-1:0] DMemRData,
  output logic                 Stall,
  output logic                 LoadValid,
  output logic [BIT_COUNT-1:0] LoadData,
  output logic                 Fault,
  output logic [1:0]           FaultCause
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]     be_q, be_d;
  logic [2:0]     f3_q, f3_d;
  logic           we_q, we_d, tmo_q, tmo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           illegal, misal;
  logic [1:0]     o;
  logic [31:0]    sh, fmt;
  always_comb begin
    o       = ALUResult[1:0];
    illegal = MemWrite ? (MemFunct3 > 3'd2) : (MemFunct3 == 3'd3 || MemFunct3[2:1] == 2'b11);
    misal   = (MemFunct3[1:0] == 2'b01 && ALUResult[0]) || (MemFunct3[1:0] == 2'b10 && o != 2'b00);
    sh      = DMemRData >> {addr_q[1:0], 3'b000};
    fmt     = f3_q[1:0] == 2'b00 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : DMemRData;
  end
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    be_d       = be_q;
    f3_d       = f3_q;
    we_d       = we_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    DMemReq    = 1'b0;
    DMemWe     = 1'b0;
    DMemAddr   = '0;
    DMemWData  = '0;
    DMemByteEn = 4'b0000;
    Stall      = 1'b0;
    LoadValid  = 1'b0;
    Fault      = 1'b0;
    FaultCause = 2'b00;
    case (state_q)
      IDLE: if (MemValid) begin
        if (illegal || misal) begin
          Fault      = 1'b1;
          FaultCause = illegal ? 2'b10 : 2'b01;
        end else begin
          Stall   = 1'b1;
          addr_d  = {ALUResult[31:2], 2'b00} | {30'd0, o};
          f3_d    = MemFunct3;
          we_d    = MemWrite;
          be_d    = MemFunct3[1:0] == 2'b00 ? 4'b0001 << o : MemFunct3[1:0] == 2'b01 ? 4'b0011 << o : 4'b1111;
          wdata_d = MemFunct3[1:0] == 2'b00 ? {4{StoreData[7:0]}} : MemFunct3[1:0] == 2'b01 ? {2{StoreData[15:0]}} : StoreData;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        DMemReq    = 1'b1;
        DMemWe     = we_q;
        DMemAddr   = {addr_q[31:2], 2'b00};
        DMemWData  = wdata_q;
        DMemByteEn = be_q;
        Stall      = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (DMemAck) begin
          state_d = DONE;
          load_d  = we_q ? load_q : fmt;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        LoadValid  = ~we_q & ~tmo_q;
        Fault      = tmo_q;
        FaultCause = tmo_q ? 2'b11 : 2'b00;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign LoadData = load_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
